// File: rtl/register_file_pkg.sv
// Shared constants and types for the parametrised register file.
package register_file_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 3;
  localparam int unsigned DefDepth     = 2 ** DefAddrWidth;

  typedef logic [DefAddrWidth-1:0] addr_t;
  typedef logic [DefDataWidth-1:0] data_t;
  typedef logic [DefDepth-1:0]     written_t;

endpackage

// File: rtl/register_file_nw_if.sv
// Read/write port bundle of the register file; slave side is the register file itself.
interface register_file_nw_if
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) ();

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] i_reg_read_0;
  logic [ADDR_WIDTH-1:0] i_reg_read_1;
  logic [DATA_WIDTH-1:0] o_port_read_0;
  logic [DATA_WIDTH-1:0] o_port_read_1;
  logic [ADDR_WIDTH-1:0] i_reg_write_0;
  logic [DATA_WIDTH-1:0] i_port_write_0;
  logic                  i_write_enable_0;
  logic [ADDR_WIDTH-1:0] i_reg_write_1;
  logic [DATA_WIDTH-1:0] i_port_write_1;
  logic                  i_write_enable_1;
  logic [DEPTH-1:0]      o_written;
  logic                  o_collision;

  modport slave (
    input  i_reg_read_0, i_reg_read_1,
    input  i_reg_write_0, i_port_write_0, i_write_enable_0,
    input  i_reg_write_1, i_port_write_1, i_write_enable_1,
    output o_port_read_0, o_port_read_1, o_written, o_collision
  );

  modport master (
    output i_reg_read_0, i_reg_read_1,
    output i_reg_write_0, i_port_write_0, i_write_enable_0,
    output i_reg_write_1, i_port_write_1, i_write_enable_1,
    input  o_port_read_0, o_port_read_1, o_written, o_collision
  );

endinterface

// File: rtl/register_file_nw_write_decoder.sv
// One write port's address+enable turned into a one-hot register strobe.
module write_decoder #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned ZERO_REG   = 1,
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  en,
  output logic [DEPTH-1:0]      strobe
);

  always_comb begin
    strobe = '0;
    if (en) strobe[addr] = 1'b1;
    // Register 0 is hardwired: never written, never flagged.
    if (ZERO_REG != 0) strobe[0] = 1'b0;
  end

endmodule

// File: rtl/register_file_nw.sv
// Two-read/two-write register file; port 1 wins same-address collisions.
module register_file_nw
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 0
) (
  input logic               i_clk,
  input logic               i_rst,
  register_file_nw_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      written_q;
  logic                  collision_q;
  logic [DEPTH-1:0]      strobe_0;
  logic [DEPTH-1:0]      strobe_1;

  write_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_dec_0 (
    .addr   (bus.i_reg_write_0),
    .en     (bus.i_write_enable_0),
    .strobe (strobe_0)
  );

  write_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_dec_1 (
    .addr   (bus.i_reg_write_1),
    .en     (bus.i_write_enable_1),
    .strobe (strobe_1)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      written_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (strobe_1[k])      regs_q[k] <= bus.i_port_write_1;
        else if (strobe_0[k]) regs_q[k] <= bus.i_port_write_0;
      end
      written_q   <= written_q | strobe_0 | strobe_1;
      // Raw enables, not strobes: a clash on the zero register still counts.
      collision_q <= bus.i_write_enable_0 & bus.i_write_enable_1 &
                     (bus.i_reg_write_0 == bus.i_reg_write_1);
    end
  end

  logic [ADDR_WIDTH-1:0] raddr [2];
  assign raddr[0] = bus.i_reg_read_0;
  assign raddr[1] = bus.i_reg_read_1;

  for (genvar p = 0; p < 2; p++) begin : g_read
    logic [DATA_WIDTH-1:0] data;
    always_comb begin
      data = regs_q[raddr[p]];
      if ((BYPASS != 0) && !i_rst) begin
        if (strobe_1[raddr[p]])      data = bus.i_port_write_1;
        else if (strobe_0[raddr[p]]) data = bus.i_port_write_0;
      end
      if ((ZERO_REG != 0) && (raddr[p] == '0)) data = '0;
    end
  end

  assign bus.o_port_read_0 = g_read[0].data;
  assign bus.o_port_read_1 = g_read[1].data;
  assign bus.o_written     = written_q;
  assign bus.o_collision   = collision_q;

endmodule

// File: doc/register_file_nw.md
Name: register_file_nw

Overview:
- Parametrised successor of the team's 4-bit, 4-entry register file.
- Configurable data width and depth.
- Two asynchronous read ports and two write ports with fixed collision priority.
- Optional hardwired zero register and optional same-cycle write-to-read bypass.
- Per-register "written since reset" flags.
- Serves as the architectural register file of the lab datapath; the ALU/control path reads operands and writes results through it.

Parameters:
- DATA_WIDTH, 8: bits per register.
- ADDR_WIDTH, 3: register index width; DEPTH = 2**ADDR_WIDTH.
- ZERO_REG, 1: 1 = register 0 always reads 0, writes to it are dropped and never set its flag.
- BYPASS, 0: 1 = a read of an address being written this cycle returns the winning write data combinationally.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_reg_read_0  in  ADDR_WIDTH  read port 0 address.
- i_reg_read_1  in  ADDR_WIDTH  read port 1 address.
- o_port_read_0  out  DATA_WIDTH  read port 0 data.
- o_port_read_1  out  DATA_WIDTH  read port 1 data.
- i_reg_write_0  in  ADDR_WIDTH  write port 0 address.
- i_port_write_0  in  DATA_WIDTH  write port 0 data.
- i_write_enable_0  in  1  write port 0 enable.
- i_reg_write_1  in  ADDR_WIDTH  write port 1 address.
- i_port_write_1  in  DATA_WIDTH  write port 1 data.
- i_write_enable_1  in  1  write port 1 enable.
- o_written  out  DEPTH  bit k = register k written since last reset.
- o_collision  out  1  registered; 1 for one cycle after an edge where both enables were set to the same address.

Behaviour:
- Reset: one clock, synchronous, active-high, as already decided.
  - On a rising edge with i_rst=1, all registers go to 0, o_written goes to 0 and o_collision goes to 0.
  - Reset overrides any write in the same cycle.
  - Reset asserted mid-sequence discards all prior contents.
  - After reset both read ports return 0 for every address.
- Reads: asynchronous (combinational) from the stored array.
  - Without bypass, a write sampled at edge N is visible on the read ports after edge N, within the same cycle following N.
  - Both read ports may address the same register.
- Writes: each enabled port writes its data at the rising edge.
  - Different addresses: both writes take effect.
  - Same address, both enabled: port 1 wins, port 0 data is dropped, and o_collision=1 for the following cycle.
- o_written: bit k is set at the edge where register k is written by either port. It stays set until reset.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - o_written[0] stays 0.
  - Both read ports return 0 for address 0, including under bypass.
  - A port-0 write to address 0 colliding with a port-1 write to address 0 still raises o_collision.
- BYPASS=1: if a read address equals an enabled write address in the same cycle, the read port outputs the winning write data (port 1 over port 0), unless:
  - i_rst=1, in which case the stored value is returned; or
  - ZERO_REG applies, in which case 0 is returned.
- BYPASS=0: reads always return stored contents.
- Read-during-write of the same address in the same cycle returns the old value.
- Width rules: no truncation or extension anywhere; all data paths are exactly DATA_WIDTH.
- Latency summary:
  - Write to visible read: 1 edge (BYPASS=0) or 0 (BYPASS=1).
  - Flags: 1 edge.

Decomposition:
- Package register_file_pkg holds:
  - default DATA_WIDTH / ADDR_WIDTH constants;
  - the DEPTH derivation;
  - typedefs for address, data and the written-flag vector.
- One sub-module, write_decoder: converts one address plus enable into a DEPTH-bit one-hot write strobe, masking bit 0 when ZERO_REG=1.
- It is instantiated once per write port; the top combines the strobes with port-1 priority.

Test Plan:
- Defaults (8/3, ZERO_REG=1, BYPASS=0).
  - Reset, then read all 8 addresses -> 0x00 on both ports, o_written=0x00.
  - Port 0 writes 0xA5 to r2 -> read port 0 on r2 shows 0x00 before the edge, 0xA5 after; o_written=0x04.
- Same-address collision: both ports write r5, port 0 0x11, port 1 0x22 -> r5 reads 0x22, o_collision=1 for one cycle then 0, o_written bit5=1.
- Parallel writes: port 0 writes 0x3C to r1 and port 1 writes 0xC3 to r7 in one cycle -> read 0 on r1 = 0x3C, read 1 on r7 = 0xC3, o_written=0x82.
- Zero register: port 0 writes 0xFF to r0 -> r0 reads 0x00, o_written[0]=0, no collision.
- BYPASS=1 build:
  - Write 0x77 to r3 while reading r3 -> 0x77 in the same cycle.
  - With i_rst=1 in that cycle -> the old value is shown, and after the edge r3=0x00.
- Mid-sequence reset: fill r1..r7 with 0x01..0x07, assert i_rst for one edge while port 1 writes r4 -> all reads 0, o_written=0x00.
